// File: rtl/pc_sequencer_if.sv
// Purpose: bundles the PC-register, imem handshake and control signals of the fetch sequencer.
// Latency: none; this is a wiring bundle.
// Backpressure: imem_req is held until imem_ack, and stall holds the instruction in execute.
interface pc_sequencer_if;
   logic [31:0] pc_cur;
   logic [31:0] pc_next;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic        instr_valid;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic        jmp;
   logic [31:0] jmp_target;
   logic        trap;
   logic        halt;
   logic        fault;
   logic        halted;
   logic [31:0] retired;

   // Sequencer side.
   modport master (
      input  pc_cur, imem_ack, stall, br_taken, br_target, jmp, jmp_target, trap, halt,
      output pc_next, imem_req, imem_addr, instr_valid, fault, halted, retired
   );

   // Core / memory side.
   modport slave (
      output pc_cur, imem_ack, stall, br_taken, br_target, jmp, jmp_target, trap, halt,
      input  pc_next, imem_req, imem_addr, instr_valid, fault, halted, retired
   );
endinterface

// File: rtl/pc_sequencer.sv
// Purpose: next-PC select and fetch sequencing (BOOT/REQ/EXEC/HALT). Optional macro PC_ALIGN_CHECK_EN traps on misaligned targets.
// Latency: an ack in cycle N gives instr_valid in cycle N+1; a redirect reaches pc_cur at the next edge.
// Backpressure: imem_req is held until imem_ack or a timeout; stall holds EXEC with pc_next=pc_cur.
module pc_sequencer #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
   parameter int          TIMEOUT   = 16
) (
   input  logic            clk,
   input  logic            rst,
   pc_sequencer_if.master  bus
);

   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_REQ  = 2'd1,
      ST_EXEC = 2'd2,
      ST_HALT = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [31:0]   retired_q, retired_d;

   logic [31:0]   pc_next;
   logic          imem_req;
   logic          instr_valid;
   logic          fault;
   logic          halted;

   logic [31:0]   tgt_raw;
   logic [31:0]   tgt;
   logic          tgt_sel;
   logic          misalign;

   // Redirect target: jump wins over branch. With the alignment check, low bits are kept so they can be tested.
   always_comb begin
      tgt_sel = bus.jmp | bus.br_taken;
      tgt_raw = bus.jmp ? bus.jmp_target : bus.br_target;
`ifdef PC_ALIGN_CHECK_EN
      misalign = tgt_sel && (tgt_raw[1:0] != 2'b00);
      tgt      = tgt_raw;
`else
      misalign = 1'b0;
      tgt      = {tgt_raw[31:2], 2'b00};
`endif
   end

   // Next-state, next-PC and fetch control; rst overrides everything in its cycle.
   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      retired_d   = retired_q;
      pc_next     = bus.pc_cur;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      fault       = 1'b0;
      halted      = 1'b0;

      if (rst) begin
         state_d   = ST_BOOT;
         wait_d    = '0;
         retired_d = '0;
         pc_next   = RESET_VEC;
      end else begin
         case (state_q)
            ST_BOOT: begin
               pc_next = RESET_VEC;
               wait_d  = '0;
               state_d = ST_REQ;
            end
            ST_REQ: begin
               imem_req = 1'b1;
               if (bus.imem_ack) begin
                  wait_d  = '0;
                  state_d = ST_EXEC;
               end else if (wait_q == WAIT_LAST) begin
                  // The fetch never completed: restart at the trap vector and keep requesting.
                  fault   = 1'b1;
                  pc_next = TRAP_VEC;
                  wait_d  = '0;
               end else begin
                  wait_d = wait_q + 1'b1;
               end
            end
            ST_EXEC: begin
               if (!bus.stall) begin
                  instr_valid = 1'b1;
                  state_d     = ST_REQ;
                  if (bus.trap) begin
                     pc_next = TRAP_VEC;
                  end else if (bus.halt) begin
                     pc_next   = bus.pc_cur;
                     state_d   = ST_HALT;
                     retired_d = retired_q + 32'd1;
                  end else if (misalign) begin
                     pc_next = TRAP_VEC;
                     fault   = 1'b1;
                  end else if (tgt_sel) begin
                     pc_next   = tgt;
                     retired_d = retired_q + 32'd1;
                  end else begin
                     pc_next   = bus.pc_cur + 32'd4;
                     retired_d = retired_q + 32'd1;
                  end
               end
            end
            ST_HALT: begin
               halted = 1'b1;
            end
            default: begin
               state_d = ST_BOOT;
            end
         endcase
      end
   end

   // State, fetch-wait counter and retired counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_BOOT;
         wait_q    <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         retired_q <= retired_d;
      end
   end

   assign bus.pc_next     = pc_next;
   assign bus.imem_req    = imem_req;
   assign bus.imem_addr   = bus.pc_cur;
   assign bus.instr_valid = instr_valid;
   assign bus.fault       = fault;
   assign bus.halted      = halted;
   assign bus.retired     = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Purpose: directed, table-driven check of pc_sequencer with a behavioural PC register.
// Latency: one table row per clock; outputs are sampled 1ns after the falling edge.
// Backpressure: imem_ack and stall are driven from the table rows.
module tb_pc_sequencer;

   localparam logic [6:0] I_NONE = 7'h00;
   localparam logic [6:0] I_RST  = 7'h40;
   localparam logic [6:0] I_ACK  = 7'h20;
   localparam logic [6:0] I_STL  = 7'h10;
   localparam logic [6:0] I_BR   = 7'h08;
   localparam logic [6:0] I_JMP  = 7'h04;
   localparam logic [6:0] I_TRP  = 7'h02;
   localparam logic [6:0] I_HLT  = 7'h01;

   typedef struct {
      logic [6:0]  in;
      logic [31:0] br_t;
      logic [31:0] jmp_t;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_iv;
      logic [31:0] e_pcn;
      logic        e_fault;
      logic        e_halted;
      logic        chk_ret;
      logic [31:0] e_ret;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_q = 32'hDEAD_BEE0;
   int          n_tests = 0;
   int          n_fail  = 0;
   vec_t        vq[$];

   pc_sequencer_if bus();

   pc_sequencer #(
      .RESET_VEC (32'h0000_0000),
      .TRAP_VEC  (32'h0000_0100),
      .TIMEOUT   (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   // Behavioural PC register: loads pc_next on every rising edge.
   always_ff @(posedge clk) pc_q <= bus.pc_next;
   assign bus.pc_cur = pc_q;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [6:0] in, input logic [31:0] br_t, input logic [31:0] jmp_t,
                      input logic e_req, input logic [31:0] e_addr, input logic e_iv,
                      input logic [31:0] e_pcn, input logic e_fault, input logic e_halted,
                      input logic chk_ret, input logic [31:0] e_ret);
      vec_t v;
      v.in = in; v.br_t = br_t; v.jmp_t = jmp_t;
      v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_pcn = e_pcn;
      v.e_fault = e_fault; v.e_halted = e_halted; v.chk_ret = chk_ret; v.e_ret = e_ret;
      vq.push_back(v);
   endtask

   task automatic drive(input logic [6:0] in, input logic [31:0] br_t, input logic [31:0] jmp_t);
      rst            = in[6];
      bus.imem_ack   = in[5];
      bus.stall      = in[4];
      bus.br_taken   = in[3];
      bus.jmp        = in[2];
      bus.trap       = in[1];
      bus.halt       = in[0];
      bus.br_target  = br_t;
      bus.jmp_target = jmp_t;
   endtask

   initial begin
      int cnt;
      drive(I_RST, 32'h0, 32'h0);

      // Reset, boot, first fetch acked after one REQ cycle.
      add(I_RST,  0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
      add(I_RST,  0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 0);
      add(I_NONE, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 0);
      add(I_NONE, 0, 0, 1, 32'h0, 0, 32'h0, 0, 0, 1, 0);
      add(I_ACK,  0, 0, 1, 32'h0, 0, 32'h0, 0, 0, 1, 0);
      add(I_NONE, 0, 0, 0, 0, 1, 32'h4, 0, 0, 1, 0);
      // Fetches with three wait cycles before the ack.
      for (int k = 0; k < 3; k++) add(I_NONE, 0, 0, 1, 32'h4, 0, 32'h4, 0, 0, 1, 1);
      add(I_ACK,  0, 0, 1, 32'h4, 0, 32'h4, 0, 0, 1, 1);
      add(I_NONE, 0, 0, 0, 0, 1, 32'h8, 0, 0, 1, 1);
      for (int k = 0; k < 3; k++) add(I_NONE, 0, 0, 1, 32'h8, 0, 32'h8, 0, 0, 1, 2);
      add(I_ACK,  0, 0, 1, 32'h8, 0, 32'h8, 0, 0, 1, 2);
      // Jump beats branch; then trap beats both and does not retire.
      add(I_BR | I_JMP, 32'h40, 32'h80, 0, 0, 1, 32'h80, 0, 0, 1, 2);
      add(I_ACK,  0, 0, 1, 32'h80, 0, 32'h80, 0, 0, 1, 3);
      add(I_BR | I_JMP | I_TRP, 32'h40, 32'h80, 0, 0, 1, 32'h100, 0, 0, 1, 3);
      add(I_ACK,  0, 0, 1, 32'h100, 0, 32'h100, 0, 0, 1, 3);
      // Three stall cycles, then one valid pulse on release.
      for (int k = 0; k < 3; k++) add(I_STL, 0, 0, 0, 0, 0, 32'h100, 0, 0, 1, 3);
      add(I_NONE, 0, 0, 0, 0, 1, 32'h104, 0, 0, 1, 3);
      // No ack: fault on the 16th REQ cycle, refetch from the trap vector.
      for (int k = 0; k < 15; k++) add(I_NONE, 0, 0, 1, 32'h104, 0, 32'h104, 0, 0, 1, 4);
      add(I_NONE, 0, 0, 1, 32'h104, 0, 32'h100, 1, 0, 1, 4);
      add(I_ACK,  0, 0, 1, 32'h100, 0, 32'h100, 0, 0, 1, 4);
      // Halt beats jump, counts as retired, and HALT ignores all inputs.
      add(I_HLT | I_JMP, 0, 32'h80, 0, 0, 1, 32'h100, 0, 0, 1, 4);
      for (int k = 0; k < 2; k++) add(I_ACK | I_TRP | I_JMP, 0, 32'h80, 0, 0, 0, 32'h100, 0, 1, 1, 5);
      // Reset out of HALT.
      add(I_RST,  0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 5);
      add(I_NONE, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 0);
      add(I_ACK,  0, 0, 1, 32'h0, 0, 32'h0, 0, 0, 1, 0);
      // Sequential wrap from 0xFFFF_FFFC.
      add(I_JMP,  0, 32'hFFFF_FFFC, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 1, 0);
      add(I_ACK,  0, 0, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 0, 1, 1);
      add(I_NONE, 0, 0, 0, 0, 1, 32'h0, 0, 0, 1, 1);
      add(I_ACK,  0, 0, 1, 32'h0, 0, 32'h0, 0, 0, 1, 2);
      // Misaligned jump target.
`ifdef PC_ALIGN_CHECK_EN
      add(I_JMP,  0, 32'h42, 0, 0, 1, 32'h100, 1, 0, 1, 2);
      add(I_NONE, 0, 0, 1, 32'h100, 0, 32'h100, 0, 0, 1, 2);
`else
      add(I_JMP,  0, 32'h42, 0, 0, 1, 32'h40, 0, 0, 1, 2);
      add(I_NONE, 0, 0, 1, 32'h40, 0, 32'h40, 0, 0, 1, 3);
`endif

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         drive(vq[i].in, vq[i].br_t, vq[i].jmp_t);
         #1;
         check($sformatf("v%0d imem_req", i), {31'b0, bus.imem_req}, {31'b0, vq[i].e_req});
         if (vq[i].e_req)
            check($sformatf("v%0d imem_addr", i), bus.imem_addr, vq[i].e_addr);
         check($sformatf("v%0d instr_valid", i), {31'b0, bus.instr_valid}, {31'b0, vq[i].e_iv});
         check($sformatf("v%0d pc_next", i), bus.pc_next, vq[i].e_pcn);
         check($sformatf("v%0d fault", i), {31'b0, bus.fault}, {31'b0, vq[i].e_fault});
         check($sformatf("v%0d halted", i), {31'b0, bus.halted}, {31'b0, vq[i].e_halted});
         if (vq[i].chk_ret)
            check($sformatf("v%0d retired", i), bus.retired, vq[i].e_ret);
      end

      // Hand-written latency sequence: reset, bounded wait for the first request, ack, then valid.
      @(negedge clk);
      drive(I_RST, 0, 0);
      @(negedge clk);
      drive(I_NONE, 0, 0);
      #1;
      cnt = 0;
      while (!bus.imem_req && cnt < 8) begin
         @(negedge clk);
         #1;
         cnt++;
      end
      check("boot_req_seen", {31'b0, bus.imem_req}, 32'd1);
      check("boot_wait_cycles", cnt, 1);
      check("boot_addr", bus.imem_addr, 32'h0);
      bus.imem_ack = 1'b1;
      @(negedge clk);
      bus.imem_ack = 1'b0;
      #1;
      check("ack_to_valid", {31'b0, bus.instr_valid}, 32'd1);
      check("ack_to_pcnext", bus.pc_next, 32'h4);
      check("ack_req_dropped", {31'b0, bus.imem_req}, 32'd0);
      @(negedge clk);
      #1;
      check("after_exec_retired", bus.retired, 32'd1);
      check("after_exec_addr", bus.imem_addr, 32'h4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
